uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver.
- Captures each completed byte on the receiver's done pulse and queues it in a power-of-two FIFO.
- Presents queued bytes to the bus side over a valid/ready handshake.
- Keeps a sticky overflow flag and a saturating count of framing errors reported by the receiver.

Parameters:
Depth, 16, number of byte entries; power of two, >= 4
CountWidth, $clog2(Depth)+1, width of occupancy count (derived, not overridden)

Ports:
clk  input  1  clock
nReset  input  1  asynchronous, active-low reset
rxData  input  8  byte from receiver; valid on the cycle after rxDone
rxDone  input  1  single-cycle pulse, one byte received
rxErr  input  1  single-cycle pulse, receiver framing/sync error
outData  output  8  head-of-queue byte; 0 when outValid=0
outValid  output  1  queue non-empty
outReady  input  1  consumer accepts head byte when outValid&&outReady
count  output  CountWidth  current occupancy, 0..Depth
overflow  output  1  sticky; byte dropped because the queue was full
errCount  output  8  saturating count of rxErr pulses
clear  input  1  synchronous clear of overflow and errCount (queue contents untouched)

Behaviour:
- Reset, asynchronous: rdPtr=0, wrPtr=0, count=0, capPend=0, outValid=0, outData=0, overflow=0, errCount=0. Storage array is not reset.
- Capture pipeline:
  - rxDone is registered into capPend.
  - The write occurs at the edge ending the capPend-high cycle, using rxData sampled that cycle.
  - Latency: rxDone high in cycle N -> write at end of N+1 -> outValid high in N+2 (if previously empty).
- Back-to-back rxDone pulses (consecutive cycles) are each captured. Each capture uses the rxData present one cycle after its own pulse.
- Push = capPend && (count<Depth || pop). Pop = outValid && outReady.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - Allowed when full.
  - Allowed when count=1: the pop takes the old head, and the new byte becomes the head next cycle.
- Push attempted when full with no pop: byte dropped, pointers/count unchanged, overflow<=1.
- Pop when count=0 is impossible, because outValid=0.
- outReady is ignored while outValid=0.
- Pointers: log2(Depth) bits, wrap naturally modulo Depth. count tracks occupancy separately.
- outValid = (count!=0). outData = mem[rdPtr] when outValid, else 0. The head is stable while outValid&&!outReady.
- errCount:
  - +1 per rxErr cycle.
  - Saturates at 255; does not wrap.
- clear:
  - Sets overflow<=0 and errCount<=0.
  - A new event in the same cycle wins: overflow<=1 if a drop occurs, errCount<=1 if rxErr=1.
- rxErr has no effect on queue contents. Bytes already captured remain valid.
- nReset mid-operation: all state returns to reset values immediately, and any pending capture is lost.

Optional Feature:
UART_RX_FIFO_RTS_EN
- Defined:
  - Adds output nRts (1 bit), a registered flow-control signal.
  - nRts<=1 (deassert, stop sender) when count reaches >= Depth-4 after an update.
  - nRts<=0 when count falls to <= Depth/2.
  - Between the thresholds nRts holds (hysteresis).
  - Reset value 0.
- Undefined: the nRts port does not exist; all other behaviour is identical.

Test Plan:
- Single byte: rxDone pulse, rxData=0xA5 next cycle, outReady=0 -> outValid=1 two cycles after the pulse, outData=0xA5, count=1. Then outReady=1 for one cycle -> count=0, outValid=0, outData=0.
- Fill/overflow: Depth=16, 17 captures of 0x00..0x10 with outReady=0 -> count=16, overflow=1. Draining yields 0x00..0x0F in order; 0x10 is absent.
- Full with simultaneous push/pop: queue full, capPend with outReady=1 in the same cycle -> count stays 16, overflow stays 0, new byte appears last.
- Wrap-around: 40 bytes streamed with outReady alternating 1/0 -> output order equals input order across pointer wrap, with no loss.
- Errors: 300 rxErr pulses -> errCount=255. Then clear with simultaneous rxErr -> errCount=1. Then clear alone -> errCount=0.
- RTS (with UART_RX_FIFO_RTS_EN, Depth=16): fill to 12 -> nRts=1. Drain to 9 -> nRts still 1. Drain to 8 -> nRts=0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and bus-side signals of uart_rx_fifo.
// nRts exists only when UART_RX_FIFO_RTS_EN is defined.
interface uart_rx_fifo_if #(parameter int Depth = 16);
  localparam int CountWidth = $clog2(Depth) + 1;
  logic [7:0] rxData;
  logic rxDone;
  logic rxErr;
  logic outReady;
  logic clear;
  logic [7:0] outData;
  logic outValid;
  logic [CountWidth-1:0] count;
  logic overflow;
  logic [7:0] errCount;
`ifdef UART_RX_FIFO_RTS_EN
  logic nRts;
  modport master(
    output rxData, rxDone, rxErr, outReady, clear,
    input outData, outValid, count, overflow, errCount, nRts
  );
  modport slave(
    input rxData, rxDone, rxErr, outReady, clear,
    output outData, outValid, count, overflow, errCount, nRts
  );
`else
  modport master(
    output rxData, rxDone, rxErr, outReady, clear,
    input outData, outValid, count, overflow, errCount
  );
  modport slave(
    input rxData, rxDone, rxErr, outReady, clear,
    output outData, outValid, count, overflow, errCount
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO behind the UART receiver with sticky overflow and framing-error count.
// Optional UART_RX_FIFO_RTS_EN adds a hysteretic nRts flow-control output.
module uart_rx_fifo #(parameter int Depth = 16) (
  input logic clk,
  input logic nReset,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(Depth);
  logic [7:0] mem [Depth];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0] err_cnt;
  logic cap_pend, ovf, valid, pop, push, drop;
  assign valid = cnt != '0;
  assign pop = valid && bus.outReady;
  // a full queue still accepts a byte when the head leaves in the same cycle
  assign push = cap_pend && (cnt != FULL || pop);
  assign drop = cap_pend && !push;
  always_comb cnt_nxt = (push && !pop) ? cnt + 1'b1 : (pop && !push) ? cnt - 1'b1 : cnt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.rxData;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      cap_pend <= 1'b0;
      ovf <= 1'b0;
      err_cnt <= '0;
    end else begin
      cap_pend <= bus.rxDone;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      cnt <= cnt_nxt;
      ovf <= drop ? 1'b1 : bus.clear ? 1'b0 : ovf;
      err_cnt <= bus.clear ? {7'd0, bus.rxErr} : (bus.rxErr && err_cnt != 8'hFF) ? err_cnt + 1'b1 : err_cnt;
    end
  assign bus.outValid = valid;
  assign bus.outData = valid ? mem[rd_ptr] : 8'h00;
  assign bus.count = cnt;
  assign bus.overflow = ovf;
  assign bus.errCount = err_cnt;
`ifdef UART_RX_FIFO_RTS_EN
  localparam logic [CW-1:0] RTS_HI = CW'(Depth - 4);
  localparam logic [CW-1:0] RTS_LO = CW'(Depth / 2);
  logic rts;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) rts <= 1'b0;
    else rts <= cnt_nxt >= RTS_HI ? 1'b1 : cnt_nxt <= RTS_LO ? 1'b0 : rts;
  assign bus.nRts = rts;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random stimulus checked against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int D = 16;
  logic clk = 1'b0;
  logic nReset;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  bit m_pend, m_ov, m_rts;
  int m_err;
  uart_rx_fifo_if #(.Depth(D)) b();
  uart_rx_fifo #(.Depth(D)) dut(.clk(clk), .nReset(nReset), .bus(b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(b.outValid), 32'(q.size() != 0));
    check({tag, ".data"}, 32'(b.outData), q.size() != 0 ? 32'(q[0]) : 32'd0);
    check({tag, ".count"}, 32'(b.count), 32'(q.size()));
    check({tag, ".ovf"}, 32'(b.overflow), 32'(m_ov));
    check({tag, ".err"}, 32'(b.errCount), 32'(m_err));
`ifdef UART_RX_FIFO_RTS_EN
    check({tag, ".rts"}, 32'(b.nRts), 32'(m_rts));
`endif
  endtask
  task automatic model_reset();
    q.delete();
    m_pend = 0;
    m_ov = 0;
    m_err = 0;
    m_rts = 0;
  endtask
  task automatic drive(input bit d, input logic [7:0] data, input bit e, input bit r, input bit c);
    b.rxDone = d;
    b.rxData = data;
    b.rxErr = e;
    b.outReady = r;
    b.clear = c;
  endtask
  task automatic tick(input string tag);
    bit pop, push;
    pop = q.size() != 0 && b.outReady;
    push = m_pend && (q.size() < D || pop);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(b.rxData);
    m_ov = (m_pend && !push) ? 1'b1 : b.clear ? 1'b0 : m_ov;
    m_err = b.clear ? int'(b.rxErr) : (b.rxErr && m_err < 255) ? m_err + 1 : m_err;
    m_pend = b.rxDone;
    m_rts = q.size() >= D - 4 ? 1'b1 : q.size() <= D / 2 ? 1'b0 : m_rts;
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    nReset = 1'b1;
    #3 nReset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    nReset = 1'b1;
    drive(1, 8'h00, 0, 0, 0);
    tick("single0");
    check("single.lat", 32'(b.outValid), 32'd0);
    drive(0, 8'hA5, 0, 0, 0);
    tick("single1");
    check("single.val", 32'(b.outValid), 32'd1);
    check("single.byte", 32'(b.outData), 32'hA5);
    drive(0, 8'h00, 0, 1, 0);
    tick("single2");
    check("single.empty", 32'(b.outData), 32'd0);
    for (int i = 0; i < 18; i++) begin
      drive(i < 17, i == 0 ? 8'h00 : 8'(i - 1), 0, 0, 0);
      tick("fill");
    end
    check("fill.count", 32'(b.count), 32'd16);
    check("fill.ovf", 32'(b.overflow), 32'd1);
    drive(0, 0, 0, 0, 1);
    tick("clr_ovf");
    drive(1, 0, 0, 0, 0);
    tick("fullpp0");
    drive(0, 8'h77, 0, 1, 0);
    tick("fullpp1");
    check("fullpp.count", 32'(b.count), 32'd16);
    check("fullpp.ovf", 32'(b.overflow), 32'd0);
    for (int i = 0; i < 18; i++) begin
      drive(0, 0, 0, 1, 0);
      tick("drain");
    end
    for (int i = 0; i < 84; i++) begin
      drive(i % 2 == 0 && i < 80, 8'($urandom), 0, i % 2 == 1, 0);
      tick("wrap");
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 1, 0);
      tick("wdrain");
    end
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 1, 0, 0);
      tick("err");
    end
    check("err.sat", 32'(b.errCount), 32'd255);
    drive(0, 0, 1, 0, 1);
    tick("err.clr_hit");
    check("err.one", 32'(b.errCount), 32'd1);
    drive(0, 0, 0, 0, 1);
    tick("err.clr");
    check("err.zero", 32'(b.errCount), 32'd0);
`ifdef UART_RX_FIFO_RTS_EN
    for (int i = 0; i < 13; i++) begin
      drive(i < 12, 8'(i + 8'h40), 0, 0, 0);
      tick("rtsfill");
    end
    check("rts.hi", 32'(b.nRts), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0);
      tick("rtsdrain");
    end
    check("rts.hold", 32'(b.nRts), 32'd1);
    drive(0, 0, 0, 1, 0);
    tick("rtsdrain8");
    check("rts.lo", 32'(b.nRts), 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 0);
      tick("rtsempty");
    end
`endif
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(1, 0) == 1, 8'($urandom), $urandom_range(7, 0) == 0,
            $urandom_range(2, 0) != 0 || i % 500 > 400, $urandom_range(49, 0) == 0);
      tick("rand");
    end
    drive(1, 8'h12, 0, 0, 0);
    tick("midrst0");
    #1 nReset = 1'b0;
    #1;
    model_reset();
    compare_all("midrst");
    nReset = 1'b1;
    drive(0, 8'h55, 0, 0, 0);
    tick("postrst");
    check("postrst.lost", 32'(b.count), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
